// File: rtl/hazard_pkg.sv
// Shared opcode/ALU constants, multdiv FSM state type and source-use predicates
// for the hazard_stall_ctrl pipeline interlock.
package hazard_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MD_RUN = 2'd1,
        MD_WB  = 2'd2
    } md_state_e;

    // Jumps and setx carry no rs operand.
    function automatic logic uses_a(input logic [4:0] opcode);
        return !(opcode == OP_J || opcode == OP_JAL || opcode == OP_SETX);
    endfunction

    function automatic logic uses_b(input logic [4:0] opcode);
        return (opcode == OP_R)  || (opcode == OP_SW) || (opcode == OP_BNE) ||
               (opcode == OP_JR) || (opcode == OP_BLT);
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multdiv sequencer: issues a single start pulse, holds MD_RUN until md_ready
// or timeout, then spends one MD_WB cycle before detection resumes.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      mul_div_i,
    input  logic      branch_i,
    input  logic      md_ready_i,
    output md_state_e state_o,
    output logic      md_start_o,
    output logic      md_busy_o,
    output logic      md_timeout_o
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             start;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mul_div_i && !branch_i) begin
                    start   = 1'b1;
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (md_ready_i) begin
                    state_d = MD_WB;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = MD_WB;
                end
            end
            MD_WB: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are forced low while reset is held, even before the reset edge lands.
    assign state_o      = state_q;
    assign md_start_o   = start && !reset;
    assign md_busy_o    = (state_q == MD_RUN) && !reset;
    assign md_timeout_o = timeout_q && !reset;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use stall, branch flush and multdiv hold control.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  fd_opcode,
    input  logic [4:0]  fd_readRegA,
    input  logic [4:0]  fd_readRegB,
    input  logic [4:0]  dx_opcode,
    input  logic [4:0]  dx_ALU_op,
    input  logic [4:0]  dx_rd,
    input  logic        x_branch_taken,
    input  logic        md_ready,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        bubble_xm,
    output logic        flush_fd,
    output logic        md_start,
    output logic        md_busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flushes,
`endif
    output logic        md_timeout
);

    md_state_e md_state;
    logic      mul_div;
    logic      load_use;
    logic      flush;

    assign mul_div = (dx_opcode == OP_R) && (dx_ALU_op == ALU_MUL || dx_ALU_op == ALU_DIV);

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clock        (clock),
        .reset        (reset),
        .mul_div_i    (mul_div),
        .branch_i     (x_branch_taken),
        .md_ready_i   (md_ready),
        .state_o      (md_state),
        .md_start_o   (md_start),
        .md_busy_o    (md_busy),
        .md_timeout_o (md_timeout)
    );

    always_comb begin
        load_use  = 1'b0;
        flush     = 1'b0;
        stall_fd  = 1'b0;
        stall_dx  = 1'b0;
        bubble_dx = 1'b0;
        bubble_xm = 1'b0;
        flush_fd  = 1'b0;
        if (!reset) begin
            // Register 0 is hardwired, so a load targeting it never blocks decode.
            load_use = (md_state == IDLE) && (dx_opcode == OP_LW) && (dx_rd != 5'd0) &&
                       ((uses_a(fd_opcode) && dx_rd == fd_readRegA) ||
                        (uses_b(fd_opcode) && dx_rd == fd_readRegB));
            flush     = x_branch_taken && (md_state != MD_RUN);
            stall_fd  = md_busy || (load_use && !flush);
            stall_dx  = md_busy;
            bubble_xm = md_busy;
            bubble_dx = load_use || flush;
            flush_fd  = flush;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_fd && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_fd && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`endif

endmodule
